// File: rtl/ldm_stm_mem_sequencer_if.sv
// Bus bundle between the LDM/STM memory sequencer and its environment
// (register address generator, register file and memory port).
interface ldm_stm_mem_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ldm_stm_start_in;
  logic [15:0]       reg_list_in;
  logic [ADDR_W-1:0] base_addr_in;
  logic [3:0]        rn_addr_in;
  logic              p_bit_in;
  logic              u_bit_in;
  logic              w_bit_in;
  logic              load_in;
  logic [3:0]        reg_addr_in;
  logic              ldm_stm_en_in;
  logic [DATA_W-1:0] reg_data_in;
  logic              mem_ready_in;
  logic [DATA_W-1:0] mem_rdata_in;
  logic              stall_out;
  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic              reg_wr_en_out;
  logic [3:0]        reg_wr_addr_out;
  logic [DATA_W-1:0] reg_wr_data_out;
  logic              rn_wb_en_out;
  logic [ADDR_W-1:0] rn_wb_data_out;
  logic              busy_out;
  logic              done_out;

  modport master (
    input  ldm_stm_start_in, reg_list_in, base_addr_in, rn_addr_in,
           p_bit_in, u_bit_in, w_bit_in, load_in,
           reg_addr_in, ldm_stm_en_in, reg_data_in,
           mem_ready_in, mem_rdata_in,
    output stall_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
           reg_wr_en_out, reg_wr_addr_out, reg_wr_data_out,
           rn_wb_en_out, rn_wb_data_out, busy_out, done_out
  );

  modport slave (
    output ldm_stm_start_in, reg_list_in, base_addr_in, rn_addr_in,
           p_bit_in, u_bit_in, w_bit_in, load_in,
           reg_addr_in, ldm_stm_en_in, reg_data_in,
           mem_ready_in, mem_rdata_in,
    input  stall_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
           reg_wr_en_out, reg_wr_addr_out, reg_wr_data_out,
           rn_wb_en_out, rn_wb_data_out, busy_out, done_out
  );
endinterface

// File: rtl/ldm_stm_mem_sequencer.sv
// LDM/STM memory-side sequencer: pairs generator register indices with word
// addresses, runs one req/ready transfer per register, then optional Rn writeback.
module ldm_stm_mem_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                    clk_in,
  input logic                    reset_in,
  ldm_stm_mem_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [ADDR_W-1:0] FOUR_C = {{(ADDR_W-3){1'b0}}, 3'b100};

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic [15:0]       list_r;
  logic [ADDR_W-1:0] base_r;
  logic [3:0]        rn_r;
  logic              p_r;
  logic              u_r;
  logic              w_r;
  logic              load_r;
  logic [4:0]        issued_r;
  logic [4:0]        xfer_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              full_r;
  logic [3:0]        hold_idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic              we_r;
  logic              reg_wr_en_r;
  logic [3:0]        reg_wr_addr_r;
  logic [DATA_W-1:0] reg_wr_data_r;
  logic              rn_wb_en_r;
  logic [ADDR_W-1:0] rn_wb_data_r;
  logic              busy_r;
  logic              done_r;

  logic [4:0]        n_s;
  logic [ADDR_W-1:0] n4_s;
  logic [ADDR_W-1:0] base_al_s;
  logic [ADDR_W-1:0] first_addr_s;
  logic [ADDR_W-1:0] wb_value_s;
  logic              start_ok_s;
  logic              ready_s;
  logic              capture_s;
  logic              last_s;
  logic              wb_take_s;
  logic              stall_s;

  // Transfer-count, address and handshake decode derived from the latched command
  always_comb begin
    n_s        = popcount16(list_r);
    n4_s       = {{(ADDR_W-7){1'b0}}, n_s, 2'b00};
    base_al_s  = {base_r[ADDR_W-1:2], 2'b00};
    wb_value_s = u_r ? (base_r + n4_s) : (base_r - n4_s);
    start_ok_s = bus.ldm_stm_start_in & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    ready_s    = (state_r == ST_XFER) & full_r & bus.mem_ready_in;
    capture_s  = (state_r == ST_XFER) & (~full_r | bus.mem_ready_in)
               & bus.ldm_stm_en_in & (issued_r < n_s);
    last_s     = ready_s & ((xfer_cnt_r + 5'd1) == n_s);
    wb_take_s  = w_r & ~(load_r & list_r[rn_r]);
    // The generator must also hold during CALC, since nothing can be captured yet.
    stall_s    = (state_r == ST_CALC) | (full_r & ~bus.mem_ready_in);
    case ({p_r, u_r})
      2'b01:   first_addr_s = base_al_s;
      2'b11:   first_addr_s = base_al_s + FOUR_C;
      2'b00:   first_addr_s = base_al_s - n4_s + FOUR_C;
      2'b10:   first_addr_s = base_al_s - n4_s;
      default: first_addr_s = base_al_s;
    endcase
  end

  // Next-state decode of the sequencing FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = start_ok_s ? ST_CALC : ST_IDLE;
      ST_CALC: state_s = (n_s == 5'd0) ? ST_DONE : ST_XFER;
      ST_XFER: begin
        if (last_s) begin
          state_s = wb_take_s ? ST_WB : ST_DONE;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_WB:   state_s = ST_DONE;
      ST_DONE: state_s = start_ok_s ? ST_CALC : ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, command latches, holding register and all registered outputs
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r       <= ST_IDLE;
      list_r        <= 16'd0;
      base_r        <= {ADDR_W{1'b0}};
      rn_r          <= 4'd0;
      p_r           <= 1'b0;
      u_r           <= 1'b0;
      w_r           <= 1'b0;
      load_r        <= 1'b0;
      issued_r      <= 5'd0;
      xfer_cnt_r    <= 5'd0;
      addr_r        <= {ADDR_W{1'b0}};
      full_r        <= 1'b0;
      hold_idx_r    <= 4'd0;
      wdata_r       <= {DATA_W{1'b0}};
      we_r          <= 1'b0;
      reg_wr_en_r   <= 1'b0;
      reg_wr_addr_r <= 4'd0;
      reg_wr_data_r <= {DATA_W{1'b0}};
      rn_wb_en_r    <= 1'b0;
      rn_wb_data_r  <= {ADDR_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r <= state_s;

      if (start_ok_s) begin
        list_r <= bus.reg_list_in;
        base_r <= bus.base_addr_in;
        rn_r   <= bus.rn_addr_in;
        p_r    <= bus.p_bit_in;
        u_r    <= bus.u_bit_in;
        w_r    <= bus.w_bit_in;
        load_r <= bus.load_in;
      end

      if (state_r == ST_CALC) begin
        addr_r     <= first_addr_s;
        xfer_cnt_r <= 5'd0;
        issued_r   <= 5'd0;
      end else if (ready_s) begin
        addr_r     <= addr_r + FOUR_C;
        xfer_cnt_r <= xfer_cnt_r + 5'd1;
      end

      // A ready cycle frees the slot, so a new entry may refill it in the same cycle.
      if (capture_s) begin
        full_r     <= 1'b1;
        hold_idx_r <= bus.reg_addr_in;
        we_r       <= ~load_r;
        wdata_r    <= load_r ? {DATA_W{1'b0}} : bus.reg_data_in;
        issued_r   <= issued_r + 5'd1;
      end else if (ready_s) begin
        full_r <= 1'b0;
        we_r   <= 1'b0;
      end

      reg_wr_en_r <= ready_s & load_r;
      if (ready_s & load_r) begin
        reg_wr_addr_r <= hold_idx_r;
        reg_wr_data_r <= bus.mem_rdata_in;
      end

      rn_wb_en_r <= (state_s == ST_WB);
      if (state_s == ST_WB) begin
        rn_wb_data_r <= wb_value_s;
      end

      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign bus.stall_out       = stall_s;
  assign bus.mem_req_out     = full_r;
  assign bus.mem_we_out      = we_r;
  assign bus.mem_addr_out    = addr_r;
  assign bus.mem_wdata_out   = wdata_r;
  assign bus.reg_wr_en_out   = reg_wr_en_r;
  assign bus.reg_wr_addr_out = reg_wr_addr_r;
  assign bus.reg_wr_data_out = reg_wr_data_r;
  assign bus.rn_wb_en_out    = rn_wb_en_r;
  assign bus.rn_wb_data_out  = rn_wb_data_r;
  assign bus.busy_out        = busy_r;
  assign bus.done_out        = done_r;

endmodule

// File: tb/tb_ldm_stm_mem_sequencer.sv
// Scoreboard bench for ldm_stm_mem_sequencer: models the register generator,
// register file and memory, and checks every transfer, write-back and done pulse.
module tb_ldm_stm_mem_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldm_stm_mem_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ldm_stm_mem_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mem_exp_t;
  typedef struct { logic [3:0] idx; logic [31:0] data; } rw_exp_t;

  mem_exp_t   exp_mem[$];
  rw_exp_t    exp_rw[$];
  logic [3:0] gen_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int wait_cnt = 0, xfer_seen = 0, done_seen = 0, wb_seen = 0;
  logic start_req = 1'b0, rst_req = 1'b1, gen_active = 1'b0, ready_slow = 1'b0;
  logic exp_wb_valid = 1'b0;
  logic [31:0] exp_wb_data = 32'd0;

  function automatic logic [31:0] rf_val(input logic [3:0] i);
    return {16'hC0DE, 4'h0, i, 4'h5, i};
  endfunction

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, settle, then score what the next posedge accepts.
  task automatic step();
    @(negedge clk);
    bus.ldm_stm_start_in = start_req;
    start_req = 1'b0;
    rst = rst_req;
    if (!ready_slow) bus.mem_ready_in = 1'b1;
    else             bus.mem_ready_in = bus.mem_req_out && (wait_cnt >= 3);
    bus.mem_rdata_in = rdata_fn(bus.mem_addr_out);
    if (gen_active) begin
      bus.ldm_stm_en_in = 1'b1;
      bus.reg_addr_in   = (gen_q.size() > 0) ? gen_q[0] : 4'hF;
    end else begin
      bus.ldm_stm_en_in = 1'b0;
      bus.reg_addr_in   = 4'h0;
    end
    bus.reg_data_in = rf_val(bus.reg_addr_in);
    #1;
    cyc++;
    if (!rst) begin
      if (bus.mem_req_out) begin
        if (exp_mem.size() == 0) begin
          check_val("extra_req", 64'd1, 64'd0);
        end else begin
          check_val("mem_addr", bus.mem_addr_out, exp_mem[0].addr);
          check_val("mem_we", bus.mem_we_out, exp_mem[0].we);
          if (exp_mem[0].we) check_val("mem_wdata", bus.mem_wdata_out, exp_mem[0].wdata);
          if (bus.mem_ready_in) begin
            exp_mem.delete(0);
            xfer_seen++;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
            check_val("stall_held", bus.stall_out, 64'd1);
          end
        end
      end
      if (bus.reg_wr_en_out) begin
        if (exp_rw.size() == 0) begin
          check_val("extra_reg_wr", 64'd1, 64'd0);
        end else begin
          check_val("reg_wr_addr", bus.reg_wr_addr_out, exp_rw[0].idx);
          check_val("reg_wr_data", bus.reg_wr_data_out, exp_rw[0].data);
          exp_rw.delete(0);
        end
      end
      if (bus.rn_wb_en_out) begin
        wb_seen++;
        check_val("rn_wb_allowed", 64'd1, {63'd0, exp_wb_valid});
        check_val("rn_wb_data", bus.rn_wb_data_out, exp_wb_data);
      end
      if (bus.done_out) begin
        done_seen++;
        done_cyc = cyc;
        gen_active = 1'b0;
      end
      if (gen_active && gen_q.size() > 0 && !bus.stall_out) gen_q.delete(0);
    end
  endtask

  task automatic start_op(input logic [15:0] list, input logic [31:0] base, input logic [3:0] rn,
                          input logic p, input logic u, input logic w, input logic ld,
                          input logic slow);
    int n;
    logic [31:0] abase, a;
    bus.reg_list_in = list; bus.base_addr_in = base; bus.rn_addr_in = rn;
    bus.p_bit_in = p; bus.u_bit_in = u; bus.w_bit_in = w; bus.load_in = ld;
    ready_slow = slow;
    exp_mem.delete(); exp_rw.delete(); gen_q.delete();
    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    abase = base & 32'hFFFF_FFFC;
    if (!p && u)      a = abase;
    else if (p && u)  a = abase + 32'd4;
    else if (!p)      a = abase - 32'(4 * n) + 32'd4;
    else              a = abase - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        exp_mem.push_back('{addr: a, we: !ld, wdata: rf_val(4'(i))});
        if (ld) exp_rw.push_back('{idx: 4'(i), data: rdata_fn(a)});
        gen_q.push_back(4'(i));
        a = a + 32'd4;
      end
    end
    exp_wb_valid = w && !(ld && list[rn]) && (n != 0);
    exp_wb_data  = u ? base + 32'(4 * n) : base - 32'(4 * n);
    done_seen = 0; wb_seen = 0; xfer_seen = 0; wait_cnt = 0;
    start_req = 1'b1;
    step();
    start_cyc = cyc;
    gen_active = 1'b1;
    step();
    check_val("busy_after_start", bus.busy_out, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int poke);
    for (int k = 0; k < 400 && done_seen == 0; k++) begin
      if (k == poke) begin
        bus.reg_list_in = 16'hFFFF;
        start_req = 1'b1;
      end
      step();
    end
    check_val({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    step();
    step();
    check_val({tag, "_single_done"}, 64'(done_seen), 64'd1);
    check_val({tag, "_busy_low"}, bus.busy_out, 64'd0);
    check_val({tag, "_mem_left"}, 64'(exp_mem.size()), 64'd0);
    check_val({tag, "_rw_left"}, 64'(exp_rw.size()), 64'd0);
    check_val({tag, "_gen_left"}, 64'(gen_q.size()), 64'd0);
    check_val({tag, "_wb_count"}, 64'(wb_seen), {63'd0, exp_wb_valid});
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_stall"}, bus.stall_out, 64'd0);
    check_val({tag, "_req"}, bus.mem_req_out, 64'd0);
    check_val({tag, "_we"}, bus.mem_we_out, 64'd0);
    check_val({tag, "_addr"}, bus.mem_addr_out, 64'd0);
    check_val({tag, "_wdata"}, bus.mem_wdata_out, 64'd0);
    check_val({tag, "_rw_en"}, bus.reg_wr_en_out, 64'd0);
    check_val({tag, "_rw_addr"}, bus.reg_wr_addr_out, 64'd0);
    check_val({tag, "_rw_data"}, bus.reg_wr_data_out, 64'd0);
    check_val({tag, "_wb_en"}, bus.rn_wb_en_out, 64'd0);
    check_val({tag, "_wb_data"}, bus.rn_wb_data_out, 64'd0);
    check_val({tag, "_busy"}, bus.busy_out, 64'd0);
    check_val({tag, "_done"}, bus.done_out, 64'd0);
  endtask

  initial begin
    bus.ldm_stm_start_in = 1'b0; bus.reg_list_in = 16'd0; bus.base_addr_in = 32'd0;
    bus.rn_addr_in = 4'd0; bus.p_bit_in = 1'b0; bus.u_bit_in = 1'b0; bus.w_bit_in = 1'b0;
    bus.load_in = 1'b0; bus.reg_addr_in = 4'd0; bus.ldm_stm_en_in = 1'b0;
    bus.reg_data_in = 32'd0; bus.mem_ready_in = 1'b0; bus.mem_rdata_in = 32'd0;

    rst_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst_req = 1'b0;
    step();
    check_idle_zero("reset");

    // IA LDM, ready tied high
    start_op(16'h6721, 32'h0000_1000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("t1_wb_value", exp_wb_data, 64'h101C);
    wait_done("t1", -1);

    // DB STM
    start_op(16'h6721, 32'h0000_1000, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done("t2", -1);

    // IB LDM with Rn in list: writeback suppressed
    start_op(16'h6721, 32'h0000_1000, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done("t3", -1);

    // DA STM, unaligned base, slow memory, stray start while busy
    start_op(16'h8421, 32'h0000_2003, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done("t4", 5);

    // Empty list
    start_op(16'h0000, 32'h0000_1000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done("t5", -1);
    check_val("t5_done_latency", 64'(done_cyc - start_cyc), 64'd2);

    // Full list, address wraparound, slow LDM
    start_op(16'hFFFF, 32'hFFFF_FFF0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done("t7_stm", -1);
    start_op(16'h00F0, 32'h0000_3000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done("t7_ldm", -1);

    // Reset after the third transfer, then a clean rerun
    start_op(16'h6721, 32'h0000_1000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 100 && xfer_seen < 3; k++) step();
    check_val("t6_reached_3", 64'(xfer_seen), 64'd3);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    gen_active = 1'b0;
    exp_mem.delete(); exp_rw.delete(); gen_q.delete();
    step();
    check_idle_zero("t6_reset");
    start_op(16'h6721, 32'h0000_1000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done("t6_rerun", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
